// File: rtl/exe_sequencer.sv
// Execute-stage sequencer: runs scalar ops in one cycle and vector ops LANES
// elements per cycle over ELEMS/LANES cycles, with flush and back-to-back issue.
module exe_sequencer #(
  parameter int ELEMS = 8,
  parameter int LANES = 2,
  parameter int DW    = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                Start_i,
  input  logic                Flush_i,
  input  logic [1:0]          OpType_i,
  input  logic [1:0]          ALUControl_i,
  input  logic [ELEMS*DW-1:0] VecA_i,
  input  logic [ELEMS*DW-1:0] VecB_i,
  input  logic [DW-1:0]       ScalarA_i,
  input  logic [DW-1:0]       ScalarB_i,
  output logic [ELEMS*DW-1:0] Result_o,
  output logic                Result_Valid_o,
  output logic                Zero_o,
  output logic                Exe_Finished_o
);

  localparam int GROUPS = ELEMS / LANES;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(GROUPS - 1);
  localparam logic [DW:0]   DW_V = (DW + 1)'(DW);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [1:0]          op_l, alu_l;
  logic [ELEMS*DW-1:0] veca_l, vecb_l;
  logic [DW-1:0]       sb_l;
  logic [ELEMS*DW-1:0] run_res;
  logic [DW-1:0]       scalar_f;
  logic                accept;

  // Shift amounts use the whole B value, so anything >= DW clears the element.
  function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a,
                                          input logic [DW-1:0] b,
                                          input logic [1:0]    ctl);
    logic big;
    big = ({1'b0, b} >= DW_V);
    case (ctl)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return big ? '0 : (a >> b);
      default: return big ? '0 : (a << b);
    endcase
  endfunction

  assign accept         = Start_i && !Flush_i && (state != RUN);
  assign scalar_f       = alu_f(ScalarA_i, ScalarB_i, ALUControl_i);
  assign Result_Valid_o = (state == DONE);
  assign Exe_Finished_o = (state != RUN);

  always_comb begin
    run_res = Result_o;
    for (int l = 0; l < LANES; l++) begin
      run_res[(int'(cnt) * LANES + l) * DW +: DW] =
        alu_f(veca_l[(int'(cnt) * LANES + l) * DW +: DW],
              (op_l == 2'b10) ? sb_l : vecb_l[(int'(cnt) * LANES + l) * DW +: DW],
              alu_l);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (Flush_i) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start_i) begin
            state_n = OpType_i[1] ? RUN : DONE;
            cnt_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end
        RUN: begin
          if (cnt == LAST) begin
            state_n = DONE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      Result_o <= '0;
      Zero_o   <= 1'b0;
    end else if (accept && !OpType_i[1]) begin
      Result_o <= (ELEMS * DW)'(scalar_f);
      Zero_o   <= (scalar_f == '0);
    end else if (state == RUN && !Flush_i) begin
      Result_o <= run_res;
    end
  end

  // Operand capture needs no reset: it is only read after an accept.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_l   <= OpType_i;
      alu_l  <= ALUControl_i;
      veca_l <= VecA_i;
      vecb_l <= VecB_i;
      sb_l   <= ScalarB_i;
    end
  end

endmodule

// File: tb/tb_exe_sequencer.sv
// Directed bench for exe_sequencer: vector table plus flush, ignored-start,
// back-to-back and asynchronous-reset sequences.
module tb_exe_sequencer;

  logic        clk, rst, start, flush;
  logic [1:0]  op, alu;
  logic [63:0] va, vb;
  logic [7:0]  sa, sb;
  logic [63:0] result;
  logic        valid, zero, finished;

  exe_sequencer #(.ELEMS(8), .LANES(2), .DW(8)) dut (
    .clk_i(clk), .rst_i(rst), .Start_i(start), .Flush_i(flush),
    .OpType_i(op), .ALUControl_i(alu), .VecA_i(va), .VecB_i(vb),
    .ScalarA_i(sa), .ScalarB_i(sb), .Result_o(result),
    .Result_Valid_o(valid), .Zero_o(zero), .Exe_Finished_o(finished)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  alu;
    logic [63:0] va;
    logic [63:0] vb;
    logic [7:0]  sa;
    logic [7:0]  sb;
    logic [63:0] res;
    logic        zero;
  } vec_t;

  vec_t tbl[12];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    op = v.op; alu = v.alu; va = v.va; vb = v.vb; sa = v.sa; sb = v.sb;
  endtask

  task automatic run_op(input vec_t v, input int k);
    int lat, busy, exp_lat;
    drive(v);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; busy = 0;
    while (!valid && lat < 20) begin
      if (!finished) busy++;
      @(posedge clk); #1;
      lat++;
    end
    exp_lat = v.op[1] ? 5 : 1;
    chk($sformatf("v%0d latency", k), 64'(lat), 64'(exp_lat));
    chk($sformatf("v%0d busy", k), 64'(busy), 64'(exp_lat - 1));
    chk($sformatf("v%0d result", k), result, v.res);
    chk($sformatf("v%0d zero", k), 64'(zero), 64'(v.zero));
    chk($sformatf("v%0d finished", k), 64'(finished), 64'd1);
    @(posedge clk); #1;
    chk($sformatf("v%0d valid_drop", k), 64'(valid), 64'd0);
  endtask

  initial begin
    int  n;
    logic seen;
    //          op     alu    VecA                    VecB                    sa     sb     result                  zero
    tbl[0]  = '{2'b01, 2'b01, 64'h0,                  64'h0,                  8'h05, 8'h05, 64'h0,                  1'b1};
    tbl[1]  = '{2'b11, 2'b00, 64'h0706050403020100,   64'hFEFEFEFEFEFEFEFE,   8'h00, 8'h00, 64'h050403020100FFFE,   1'b1};
    tbl[2]  = '{2'b10, 2'b11, 64'h8181818181818181,   64'h0,                  8'h00, 8'h01, 64'h0202020202020202,   1'b1};
    tbl[3]  = '{2'b10, 2'b11, 64'h8181818181818181,   64'h0,                  8'h00, 8'h09, 64'h0,                  1'b1};
    tbl[4]  = '{2'b01, 2'b00, 64'h0,                  64'h0,                  8'h7F, 8'h01, 64'h80,                 1'b0};
    tbl[5]  = '{2'b01, 2'b00, 64'h0,                  64'h0,                  8'hFF, 8'h01, 64'h0,                  1'b1};
    tbl[6]  = '{2'b01, 2'b10, 64'h0,                  64'h0,                  8'h80, 8'h07, 64'h01,                 1'b0};
    tbl[7]  = '{2'b00, 2'b11, 64'h0,                  64'h0,                  8'h01, 8'h08, 64'h0,                  1'b1};
    tbl[8]  = '{2'b11, 2'b01, 64'h0706050403020100,   64'h0101010101010101,   8'h00, 8'h00, 64'h06050403020100FF,   1'b1};
    tbl[9]  = '{2'b11, 2'b10, 64'hF0F0F0F0F0F0F0F0,   64'h0706050403020100,   8'h00, 8'h00, 64'h0103070F1E3C78F0,   1'b1};
    tbl[10] = '{2'b01, 2'b10, 64'h0,                  64'h0,                  8'h12, 8'h00, 64'h12,                 1'b0};
    tbl[11] = '{2'b10, 2'b01, 64'h1010101010101010,   64'h0,                  8'h00, 8'h11, 64'hFFFFFFFFFFFFFFFF,   1'b0};

    rst = 1'b1; start = 1'b0; flush = 1'b0;
    op = '0; alu = '0; va = '0; vb = '0; sa = '0; sb = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst result", result, 64'h0);
    chk("rst valid", 64'(valid), 64'd0);
    chk("rst zero", 64'(zero), 64'd0);
    chk("rst finished", 64'(finished), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 12; k++) run_op(tbl[k], k);

    // Flush in the second RUN cycle; a start raised during RUN must be ignored
    drive(tbl[1]);
    start = 1'b1;
    @(posedge clk); #1;
    op = 2'b01; alu = 2'b00; sa = 8'h03; sb = 8'h04;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    chk("flush finished", 64'(finished), 64'd1);
    chk("flush valid", 64'(valid), 64'd0);
    chk("flush result", result, 64'hFFFFFFFFFFFFFFFE);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (valid) seen = 1'b1;
    end
    chk("flush no_pulse", 64'(seen), 64'd0);
    chk("flush result_hold", result, 64'hFFFFFFFFFFFFFFFE);

    // Start re-raised with different operands mid-RUN must not disturb the op
    drive(tbl[1]);
    start = 1'b1;
    @(posedge clk); #1;
    op = 2'b01; alu = 2'b00; va = '0; vb = '0; sa = 8'h03; sb = 8'h04;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 3;
    while (!valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ign latency", 64'(n), 64'd5);
    chk("ign result", result, 64'h050403020100FFFE);
    @(posedge clk); #1;

    // Back-to-back: Start held high, second op accepted in DONE
    drive(tbl[2]);
    start = 1'b1;
    @(posedge clk); #1;
    n = 1;
    while (!valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b first latency", 64'(n), 64'd5);
    chk("b2b first result", result, 64'h0202020202020202);
    op = 2'b01; alu = 2'b00; sa = 8'h03; sb = 8'h04;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b second valid", 64'(valid), 64'd1);
    chk("b2b second result", result, 64'h7);
    chk("b2b second zero", 64'(zero), 64'd0);
    @(posedge clk); #1;
    chk("b2b valid_drop", 64'(valid), 64'd0);

    // Asynchronous reset mid-RUN, then start on the first edge after release
    drive(tbl[1]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst result", result, 64'h0);
    chk("arst finished", 64'(finished), 64'd1);
    chk("arst valid", 64'(valid), 64'd0);
    chk("arst zero", 64'(zero), 64'd0);
    #1;
    rst = 1'b0;
    op = 2'b01; alu = 2'b00; sa = 8'h01; sb = 8'h01;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("post_rst valid", 64'(valid), 64'd1);
    chk("post_rst result", result, 64'h2);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
